uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte requesters sharing one uart_tx (legal range 2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 65535, clk cycles allowed in WAIT_DONE before abort; 0 disables the timeout.
REQ-003 Parameter GAP_CYCLES, default 0, idle clk cycles inserted after each tx_done before the next grant.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  bit i high: requester i holds a byte for transmission.
REQ-007 req_data  input  8*NUM_REQ  requester i byte at bits [8i+7:8i].
REQ-008 req_ready  output  NUM_REQ  one-hot acceptance strobe; byte i is taken in the cycle when req_valid[i] and req_ready[i] are both high.
REQ-009 tx_start  output  1  one-cycle start pulse to uart_tx.
REQ-010 tx_data  output  8  byte presented to uart_tx.
REQ-011 tx_done  input  1  completion pulse from uart_tx.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 grant_id  output  clog2(NUM_REQ)  index of the most recently accepted requester.
REQ-014 timeout_err  output  1  one-cycle pulse on timeout abort.

Function
REQ-015 The FSM SHALL have states IDLE, START, WAIT_DONE, GAP.
REQ-016 IDLE: when any req_valid bit is high, req_ready SHALL be driven combinationally to the single winner; the FSM SHALL then latch req_data of the winner into tx_data, set grant_id, and go to START.
REQ-017 Arbitration SHALL be round-robin: search order is last_grant+1, last_grant+2, ..., wrapping modulo NUM_REQ; last_grant updates only on acceptance.
REQ-018 req_ready SHALL be all-zero in START, WAIT_DONE, GAP, and in IDLE when req_valid is zero.
REQ-019 START: tx_start SHALL be high for exactly this one cycle, with the next state WAIT_DONE; tx_done in START SHALL be ignored.
REQ-020 Latency: acceptance in cycle N SHALL give tx_start high in cycle N+1.
REQ-021 tx_data SHALL remain stable from START until the next acceptance.
REQ-022 WAIT_DONE: on tx_done, go to GAP if GAP_CYCLES>0, else IDLE.
REQ-023 GAP SHALL last exactly GAP_CYCLES cycles, then go to IDLE.
REQ-024 With GAP_CYCLES=0, tx_done in cycle M SHALL permit the next acceptance in cycle M+1 and the next tx_start in cycle M+2.
REQ-025 The timeout counter SHALL clear on entry to WAIT_DONE and increment each WAIT_DONE cycle without tx_done.
REQ-026 When the count reaches TIMEOUT_CYCLES (nonzero) without tx_done, timeout_err SHALL pulse for one cycle and the FSM SHALL go to IDLE; the byte is dropped and not retried.
REQ-027 When tx_done arrives in the same cycle the count reaches its limit, tx_done SHALL win and timeout_err SHALL stay low.
REQ-028 tx_done in IDLE or GAP SHALL be ignored and SHALL NOT change state.
REQ-029 Deasserting req_valid[i] without acceptance SHALL withdraw the request with no side effects.

Reset
REQ-030 rst high SHALL immediately force state IDLE, req_ready=0, tx_start=0, tx_data=8'h00, busy=0, grant_id=0, timeout_err=0, timeout counter=0, and last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-031 rst asserted mid-frame SHALL abandon the transfer without generating tx_start; the bench SHALL reset uart_tx together with the arbiter.

Verification
REQ-032 Single request: req_valid=4'b0001, req_data[7:0]=8'h55 after reset -> req_ready=4'b0001 for one cycle, tx_start one cycle later with tx_data=8'h55, busy high until tx_done.
REQ-033 All four requesters held valid with bytes 8'hA0..8'hA3 -> tx_data sequence A0, A1, A2, A3, A0, and each req_ready pulse is one-hot.
REQ-034 Requesters 1 and 3 valid, last_grant=1 -> requester 3 granted next, then 1; grant_id follows 3, 1.
REQ-035 TIMEOUT_CYCLES=20 and tx_done held low -> timeout_err pulses 20 cycles after entry to WAIT_DONE, the FSM returns to IDLE, and the next pending request is granted.
REQ-036 GAP_CYCLES=3 -> exactly 3 cycles of busy=1 with req_ready=0 after tx_done, before the next acceptance.
REQ-037 rst pulsed during WAIT_DONE while driving 8'hAB -> outputs reach reset values immediately, no stray tx_start occurs, and requester 0 wins first after release.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between NUM_REQ byte requesters.
// Requests are granted round-robin, one frame at a time. A stalled frame
// is abandoned after TIMEOUT_CYCLES, and an optional idle gap of GAP_CYCLES
// can follow each completed frame.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int GAP_CYCLES     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_done,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       timeout_err
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    // Last counter value before the limit is reached; the limit itself is
    // hit on the edge that leaves this value without seeing tx_done.
    localparam logic [TCW-1:0] TIMEOUT_LIMIT =
        (TIMEOUT_CYCLES > 0) ? TCW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [GCW-1:0] GAP_LIMIT =
        (GAP_CYCLES > 0) ? GCW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;
    logic [TCW-1:0]   to_cnt_q, to_cnt_d;
    logic [GCW-1:0]   gap_cnt_q, gap_cnt_d;
    logic             timeout_err_q, timeout_err_d;

    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic [7:0]       win_byte;

    // Round-robin search starting one past the last accepted requester.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        win_byte   = 8'h00;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!win_found && req_valid[i] &&
                    (i == ((int'(last_grant_q) + k) % NUM_REQ))) begin
                    win_found     = 1'b1;
                    win_idx       = IDW'(i);
                    win_onehot[i] = 1'b1;
                    win_byte      = req_data[8*i +: 8];
                end
            end
        end
    end

    // Next-state logic: grant in IDLE, pulse start, wait for completion or
    // timeout, then optionally hold off in GAP before the next grant.
    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        to_cnt_d      = to_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    tx_data_d    = win_byte;
                    grant_id_d   = win_idx;
                    last_grant_d = win_idx;
                    state_d      = START;
                end
            end
            START: begin
                to_cnt_d = '0;
                state_d  = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else if ((TIMEOUT_CYCLES > 0) && (to_cnt_q == TIMEOUT_LIMIT)) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TCW'(1);
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LIMIT) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset leaves requester 0 first in line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            tx_data_q     <= 8'h00;
            grant_id_q    <= '0;
            last_grant_q  <= IDW'(NUM_REQ - 1);
            to_cnt_q      <= '0;
            gap_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            grant_id_q    <= grant_id_d;
            last_grant_q  <= last_grant_d;
            to_cnt_q      <= to_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Acceptance strobe is combinational so a byte is taken in the same
    // cycle it is offered; held low while reset is asserted.
    always_comb begin
        req_ready = '0;
        if ((state_q == IDLE) && !rst) begin
            req_ready = win_onehot;
        end
    end

    assign tx_start    = (state_q == START);
    assign busy        = (state_q != IDLE);
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_id_q;
    assign timeout_err = timeout_err_q;

endmodule
